// File: rtl/alu_pkg.sv
// Shared definitions for the FIFO_IN -> ALU input control unit.
//   - opcode encodings carried in each FIFO_IN entry
//   - FSM state encoding for in_alu_control_unit
//   - field offsets of the FIFO_IN entry {id, opcode, operand_a, operand_b}
package alu_pkg;

    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_MUL = 2'b10;
    localparam logic [1:0] OPC_ILL = 2'b11;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_DISPATCH = 2'd2;

    // Entry layout, LSB first: operand_b, operand_a, opcode, id.
    function automatic int unsigned fld_b_lsb(int unsigned data_size);
        return 0;
    endfunction

    function automatic int unsigned fld_a_lsb(int unsigned data_size);
        return data_size;
    endfunction

    function automatic int unsigned fld_opc_lsb(int unsigned data_size);
        return 2 * data_size;
    endfunction

    function automatic int unsigned fld_id_lsb(int unsigned data_size, int unsigned opc_size);
        return 2 * data_size + opc_size;
    endfunction

endpackage

// File: rtl/in_alu_op_decode.sv
// Combinational opcode decoder for the input control unit.
// Ports:
//   opcode_i   - opcode field of the held FIFO_IN entry
//   add_sel_o  - operation targets the adder (ADD or SUB)
//   mul_sel_o  - operation targets the multiplier
//   sub_o      - adder should subtract
//   illegal_o  - opcode is not a defined operation; entry is dropped
module in_alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned OPC_SIZE = 2
) (
    input  logic [OPC_SIZE-1:0] opcode_i,
    output logic                add_sel_o,
    output logic                mul_sel_o,
    output logic                sub_o,
    output logic                illegal_o
);

    always_comb begin
        add_sel_o = 1'b0;
        mul_sel_o = 1'b0;
        sub_o     = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_SIZE'(OPC_ADD): add_sel_o = 1'b1;
            OPC_SIZE'(OPC_SUB): begin
                add_sel_o = 1'b1;
                sub_o     = 1'b1;
            end
            OPC_SIZE'(OPC_MUL): mul_sel_o = 1'b1;
            default:            illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/in_alu_control_unit.sv
// Input-side control unit: pops tagged operations from FIFO_IN, decodes them and
// presents operands + ID to the adder or multiplier over a valid/ready handshake.
// Illegal opcodes are dropped, pulsed on illegal_op and counted (saturating).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   empty_f_in        - FIFO_IN empty flag
//   fifo_in_data      - FIFO_IN read data, valid the cycle after r_en_in
//   r_en_in           - FIFO_IN pop strobe
//   add_ready         - adder accepts an operation
//   mul_ready         - multiplier accepts an operation
//   a_valid_op        - operation presented to the adder
//   m_valid_op        - operation presented to the multiplier
//   op_sub            - adder mode (1 = subtract)
//   op_a, op_b, op_id - operands and transaction ID from the hold register
//   illegal_op        - one-cycle pulse when an illegal entry is dropped
//   illegal_cnt       - saturating count of dropped entries
// FIFO_IN_WIDTH must equal ID_SIZE + OPC_SIZE + 2*DATA_SIZE.
module in_alu_control_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = 16,
    parameter int unsigned ID_SIZE       = 8,
    parameter int unsigned OPC_SIZE      = 2,
    parameter int unsigned FIFO_IN_WIDTH = 42,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     empty_f_in,
    input  logic [FIFO_IN_WIDTH-1:0] fifo_in_data,
    output logic                     r_en_in,
    input  logic                     add_ready,
    input  logic                     mul_ready,
    output logic                     a_valid_op,
    output logic                     m_valid_op,
    output logic                     op_sub,
    output logic [DATA_SIZE-1:0]     op_a,
    output logic [DATA_SIZE-1:0]     op_b,
    output logic [ID_SIZE-1:0]       op_id,
    output logic                     illegal_op,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    localparam int unsigned BLsb   = fld_b_lsb(DATA_SIZE);
    localparam int unsigned ALsb   = fld_a_lsb(DATA_SIZE);
    localparam int unsigned OpcLsb = fld_opc_lsb(DATA_SIZE);
    localparam int unsigned IdLsb  = fld_id_lsb(DATA_SIZE, OPC_SIZE);

    logic [1:0]           state_q, state_d;
    logic [ID_SIZE-1:0]   id_q;
    logic [OPC_SIZE-1:0]  opc_q;
    logic [DATA_SIZE-1:0] a_q, b_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic add_sel, mul_sel, sub, illegal;
    logic done;

    in_alu_op_decode #(
        .OPC_SIZE (OPC_SIZE)
    ) u_op_decode (
        .opcode_i  (opc_q),
        .add_sel_o (add_sel),
        .mul_sel_o (mul_sel),
        .sub_o     (sub),
        .illegal_o (illegal)
    );

    always_comb begin
        state_d    = state_q;
        r_en_in    = 1'b0;
        a_valid_op = 1'b0;
        m_valid_op = 1'b0;
        op_sub     = 1'b0;
        illegal_op = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_f_in) begin
                    r_en_in = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DISPATCH;
            S_DISPATCH: begin
                a_valid_op = add_sel;
                m_valid_op = mul_sel;
                op_sub     = add_sel & sub;
                illegal_op = illegal;
                // Illegal entries complete unconditionally; readies of untargeted units are ignored.
                done = illegal | (add_sel & add_ready) | (mul_sel & mul_ready);
                if (done) begin
                    if (!empty_f_in) begin
                        r_en_in = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Never pop during reset: the popped entry would be lost.
        if (rst) begin
            r_en_in = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                id_q  <= fifo_in_data[IdLsb +: ID_SIZE];
                opc_q <= fifo_in_data[OpcLsb +: OPC_SIZE];
                a_q   <= fifo_in_data[ALsb +: DATA_SIZE];
                b_q   <= fifo_in_data[BLsb +: DATA_SIZE];
            end
            if (illegal_op && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign op_a        = a_q;
    assign op_b        = b_q;
    assign op_id       = id_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/in_alu_control_unit.md
Name: in_alu_control_unit

Overview:
Input-side control unit between FIFO_IN and the ALU (adder and multiplier); it is the counterpart of the output control unit that writes ALU results into FIFO_OUT.
- Pops tagged operation entries from FIFO_IN and decodes the opcode.
- Presents operands plus the 8-bit ID to the adder or multiplier using a valid/ready handshake.
- Drops illegal opcodes and counts them.

Parameters:
DATA_SIZE, 16, width of each operand.
ID_SIZE, 8, width of the transaction ID carried with each operation to the result path.
OPC_SIZE, 2, opcode width.
FIFO_IN_WIDTH, 42, FIFO_IN entry width; must equal ID_SIZE+OPC_SIZE+2*DATA_SIZE.
CNT_WIDTH, 8, width of the illegal-opcode counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
empty_f_in  input  1  FIFO_IN empty flag.
fifo_in_data  input  FIFO_IN_WIDTH  FIFO_IN read data; valid the cycle after r_en_in=1. Layout is {id, opcode, operand_a, operand_b}, with id at the MSBs.
r_en_in  output  1  FIFO_IN read strobe (pop).
add_ready  input  1  adder can accept an operation.
mul_ready  input  1  multiplier can accept an operation.
a_valid_op  output  1  operation presented to the adder.
m_valid_op  output  1  operation presented to the multiplier.
op_sub  output  1  adder mode: 0=add, 1=subtract (meaningful only when a_valid_op=1).
op_a  output  DATA_SIZE  operand A.
op_b  output  DATA_SIZE  operand B.
op_id  output  ID_SIZE  transaction ID.
illegal_op  output  1  one-cycle pulse when an illegal opcode is dropped.
illegal_cnt  output  CNT_WIDTH  saturating count of dropped entries.

Behaviour:
- Opcodes: 00=ADD, 01=SUB (both to the adder), 10=MUL (to the multiplier), 11=ILLEGAL.
- Reset values: state IDLE; r_en_in, a_valid_op, m_valid_op, op_sub, illegal_op = 0; op_a, op_b, op_id, illegal_cnt = 0.
- r_en_in is forced to 0 whenever rst=1.
- FSM has three states: IDLE, FETCH, DISPATCH.
- IDLE:
  - r_en_in = !empty_f_in, combinational.
  - If r_en_in=1, go to FETCH; otherwise stay in IDLE.
- FETCH:
  - fifo_in_data is valid this cycle.
  - Capture id, opcode, operand_a and operand_b into the hold register.
  - Go to DISPATCH. r_en_in=0.
- DISPATCH, adder ops (ADD/SUB):
  - a_valid_op=1; op_sub = opcode[0].
  - op_a, op_b, op_id are driven from the hold register and stay stable while valid is high.
  - Transfer completes in any cycle where a_valid_op & add_ready.
  - Valid must not drop before transfer, and the hold register must not change before transfer.
- DISPATCH, MUL: m_valid_op=1, with the same rules as the adder case using mul_ready.
- DISPATCH, ILLEGAL:
  - No valid is raised. illegal_op pulses for this one cycle.
  - illegal_cnt increments and saturates at all-ones, with no wrap.
  - Treated as completing in this cycle.
- On completion in DISPATCH:
  - If !empty_f_in: r_en_in=1 in the same cycle and next state is FETCH (back-to-back pipelining).
  - Otherwise: next state is IDLE.
- Latency and throughput:
  - Valid rises 2 cycles after the pop cycle.
  - Sustained throughput is one operation per 2 cycles when the FIFO is non-empty and the units are always ready.
- a_valid_op and m_valid_op are never high in the same cycle.
- Exactly one pop occurs per dispatched or dropped entry.
- A ready input that rises while its unit is not targeted is ignored. Ready may be high before valid.
- While in DISPATCH, empty_f_in changes have no effect until completion.
- Reset mid-operation: any entry already popped and not yet transferred is discarded (not re-read); outputs go to their reset values on the next edge.
- Outside DISPATCH: op_a, op_b, op_id hold their last captured values; valids are 0.

Decomposition:
- Package alu_pkg:
  - opcode constants OPC_ADD, OPC_SUB, OPC_MUL, OPC_ILL;
  - FSM state encoding (S_IDLE, S_FETCH, S_DISPATCH);
  - field offset constants for the FIFO_IN entry layout.
- One natural sub-module: in_alu_op_decode, combinational. It maps the opcode to add_sel, mul_sel, sub and illegal.
- FSM, hold register and counter stay in the top module.

Test Plan:
- Single ADD: FIFO holds {8'h05, 2'b00, 16'h0003, 16'h0004}; add_ready=1 → r_en_in pulse at cycle t, a_valid_op=1 at t+2 with op_a=3, op_b=4, op_id=5, op_sub=0; a_valid_op=0 at t+3.
- Backpressure MUL: entry {8'h0A, 2'b10, 16'h0010, 16'h0002}; mul_ready=0 for 5 cycles, then 1 → m_valid_op held 6 cycles with operands stable; one pop only; a_valid_op stays 0.
- Back-to-back: 4 queued entries (SUB, MUL, ADD, SUB); both readys=1 → valids at t+2, t+4, t+6, t+8; r_en_in at t, t+2, t+4, t+6; op_sub=1 on the first and last operations.
- Illegal: entry with opcode 2'b11 → no valid; illegal_op single pulse; illegal_cnt=1. Force 300 illegal entries with CNT_WIDTH=8 → illegal_cnt saturates at 255.
- Reset mid-dispatch: assert rst while a_valid_op=1 and add_ready=0 → next edge all outputs 0, state IDLE. With 1 entry left in the FIFO, it is popped 1 cycle after rst deasserts; the discarded entry never appears.
- Empty FIFO: empty_f_in=1 for 20 cycles → r_en_in, a_valid_op, m_valid_op remain 0.
